// File: rtl/seq_unlock_detector.sv
// -----------------------------------------------------------------------------
// seq_unlock_detector
//
// Watches a stream of qualified accesses for any of NUM_KEYS secret address
// sequences (each KEY_LEN entries long). When a full sequence is seen, the
// block enters STREAM and shifts out that channel's RESP_W-bit response word,
// LSB first, one bit per subsequent access. Partial progress in HUNT is
// discarded after TIMEOUT consecutive idle cycles.
//
// Ports
//   clk        : clock, all state changes on rising edge
//   rst        : synchronous active-high reset
//   acc_valid  : one qualified access this cycle
//   acc_addr   : compared address field of the access
//   keys       : key k entry i at [(k*KEY_LEN+i)*ADDR_W +: ADDR_W]
//   resp       : response word of key k at [k*RESP_W +: RESP_W]
//   unlocked   : high while streaming
//   unlock_id  : channel that last unlocked
//   sdrd       : current response data bit (registered)
//   sdrd_oe    : sdrd drive enable
// -----------------------------------------------------------------------------
module seq_unlock_detector #(
  parameter int ADDR_W   = 4,
  parameter int KEY_LEN  = 6,
  parameter int NUM_KEYS = 2,
  parameter int RESP_W   = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          acc_valid,
  input  logic [ADDR_W-1:0]                             acc_addr,
  input  logic [NUM_KEYS*KEY_LEN*ADDR_W-1:0]            keys,
  input  logic [NUM_KEYS*RESP_W-1:0]                    resp,
  output logic                                          unlocked,
  output logic [((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0] unlock_id,
  output logic                                          sdrd,
  output logic                                          sdrd_oe
);

  localparam int ID_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int IDX_W  = $clog2(KEY_LEN);
  localparam int CNT_W  = $clog2(RESP_W + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Key / response unpacking
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] key_tab  [NUM_KEYS][KEY_LEN];
  logic [RESP_W-1:0] resp_tab [NUM_KEYS];

  genvar gk, gi;
  generate
    for (gk = 0; gk < NUM_KEYS; gk++) begin : g_unpack
      assign resp_tab[gk] = resp[gk*RESP_W +: RESP_W];
      for (gi = 0; gi < KEY_LEN; gi++) begin : g_entry
        assign key_tab[gk][gi] = keys[(gk*KEY_LEN + gi)*ADDR_W +: ADDR_W];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_reg,   state_next;
  logic [IDX_W-1:0]   idx_reg      [NUM_KEYS];
  logic [IDX_W-1:0]   idx_next     [NUM_KEYS];
  logic [IDLE_W-1:0]  idle_reg,    idle_next;
  logic [RESP_W-1:0]  shift_reg,   shift_next;
  logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [ID_W-1:0]    id_reg,      id_next;

  // ---------------------------------------------------------------------------
  // Per-channel matching
  //   hit       : address equals the entry this channel is waiting for
  //   first_hit : address equals entry 0, so a mismatch restarts at index 1
  //   done      : hit on the last entry (sequence complete, if acc_valid)
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] hit;
  logic [NUM_KEYS-1:0] first_hit;
  logic [NUM_KEYS-1:0] done;
  logic [IDX_W-1:0]    idx_step [NUM_KEYS];

  generate
    for (gk = 0; gk < NUM_KEYS; gk++) begin : g_chan
      assign hit[gk]       = (acc_addr == key_tab[gk][idx_reg[gk]]);
      assign first_hit[gk] = (acc_addr == key_tab[gk][0]);
      assign done[gk]      = hit[gk] && (idx_reg[gk] == IDX_W'(KEY_LEN - 1));
      assign idx_step[gk]  = hit[gk]       ? IDX_W'(idx_reg[gk] + 1'b1) :
                             first_hit[gk] ? IDX_W'(1) : '0;
    end
  endgenerate

  // Lowest completing channel wins; scan from the top so the last write is
  // the lowest index.
  logic            win_any;
  logic [ID_W-1:0] win_id;

  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (done[k]) begin
        win_any = 1'b1;
        win_id  = ID_W'(k);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    idle_next    = idle_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    id_next      = id_reg;

    case (state_reg)
      ST_HUNT: begin
        if (acc_valid) begin
          idle_next = '0;
          if (win_any) begin
            state_next   = ST_STREAM;
            id_next      = win_id;
            shift_next   = resp_tab[win_id];
            bit_cnt_next = '0;
            for (int k = 0; k < NUM_KEYS; k++) idx_next[k] = '0;
          end else begin
            idx_next = idx_step;
          end
        end else begin
          if (idle_reg != IDLE_W'(TIMEOUT)) begin
            idle_next = IDLE_W'(idle_reg + 1'b1);
          end
          // This idle cycle is the TIMEOUT-th in a row (or later): drop progress.
          if (idle_reg >= IDLE_W'(TIMEOUT - 1)) begin
            for (int k = 0; k < NUM_KEYS; k++) idx_next[k] = '0;
          end
        end
      end

      ST_STREAM: begin
        // Address content is ignored here and the idle timer is parked.
        idle_next = '0;
        if (acc_valid) begin
          if (bit_cnt_reg == CNT_W'(RESP_W - 1)) begin
            state_next   = ST_HUNT;
            shift_next   = '0;
            bit_cnt_next = '0;
          end else begin
            shift_next   = shift_reg >> 1;
            bit_cnt_next = CNT_W'(bit_cnt_reg + 1'b1);
          end
        end
      end

      default: begin
        state_next = ST_HUNT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_HUNT;
      for (int k = 0; k < NUM_KEYS; k++) idx_reg[k] <= '0;
      idle_reg    <= '0;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      id_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      idle_reg    <= idle_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      id_reg      <= id_next;
    end
  end

  // Outputs decode registers only; nothing from the inputs reaches them
  // combinationally.
  assign unlocked  = (state_reg == ST_STREAM);
  assign sdrd_oe   = (state_reg == ST_STREAM);
  assign sdrd      = (state_reg == ST_STREAM) & shift_reg[0];
  assign unlock_id = id_reg;

endmodule

// File: tb/tb_seq_unlock_detector.sv
module tb_seq_unlock_detector;

  localparam int ADDR_W   = 4;
  localparam int KEY_LEN  = 4;
  localparam int NUM_KEYS = 2;
  localparam int RESP_W   = 8;
  localparam int TIMEOUT  = 10;

  logic                                 clk = 1'b0;
  logic                                 rst = 1'b1;
  logic                                 acc_valid = 1'b0;
  logic [ADDR_W-1:0]                    acc_addr = '0;
  logic [NUM_KEYS*KEY_LEN*ADDR_W-1:0]   keys;
  logic [NUM_KEYS*RESP_W-1:0]           resp;
  logic                                 unlocked;
  logic [0:0]                           unlock_id;
  logic                                 sdrd;
  logic                                 sdrd_oe;

  seq_unlock_detector #(
    .ADDR_W   (ADDR_W),
    .KEY_LEN  (KEY_LEN),
    .NUM_KEYS (NUM_KEYS),
    .RESP_W   (RESP_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .acc_valid (acc_valid),
    .acc_addr  (acc_addr),
    .keys      (keys),
    .resp      (resp),
    .unlocked  (unlocked),
    .unlock_id (unlock_id),
    .sdrd      (sdrd),
    .sdrd_oe   (sdrd_oe)
  );

  always #5 clk = ~clk;

  // One record per clock: inputs applied before the edge, outputs expected
  // just after it.
  typedef struct {
    logic       r;
    logic       v;
    logic [3:0] a;
    logic       u;
    logic       id;
    logic       s;
    logic       oe;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_step = 0;

  task automatic add(input logic r, input logic v, input logic [3:0] a,
                     input logic u, input logic id, input logic s, input logic oe);
    vec_t t;
    t.r = r; t.v = v; t.a = a; t.u = u; t.id = id; t.s = s; t.oe = oe;
    tbl.push_back(t);
  endtask

  // HUNT cycle: outputs low, unlock_id holding
  task automatic h(input logic v, input logic [3:0] a, input logic id);
    add(1'b0, v, a, 1'b0, id, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input logic id);
    repeat (n) h(1'b0, 4'h0, id);
  endtask

  // Four back-to-back accesses; the last one completes and streams bit 0.
  task automatic unlock4(input logic [3:0] a0, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [3:0] a3,
                         input logic id_before, input logic id_after,
                         input logic b0);
    h(1'b1, a0, id_before);
    h(1'b1, a1, id_before);
    h(1'b1, a2, id_before);
    add(1'b0, 1'b1, a3, 1'b1, id_after, b0, 1'b1);
  endtask

  // Remaining bits 1..7, with a long idle gap mid-stream that must neither
  // advance the stream nor time it out, then the final access back to HUNT.
  task automatic stream_rest(input logic [7:0] r, input logic id);
    logic [3:0] a;
    for (int i = 1; i < 8; i++) begin
      a = i[0] ? 4'hA : 4'h5;
      add(1'b0, 1'b1, a, 1'b1, id, r[i], 1'b1);
      if (i == 3) repeat (12) add(1'b0, 1'b0, 4'h0, 1'b1, id, r[3], 1'b1);
    end
    h(1'b1, 4'h3, id);
  endtask

  task automatic check();
    vec_t e;
    e = exp_q.pop_front();
    n_cmp++;
    if ({unlocked, unlock_id, sdrd, sdrd_oe} !== {e.u, e.id, e.s, e.oe}) begin
      n_bad++;
      $display("FAIL step%0d: got unlocked=%b id=%b sdrd=%b oe=%b, need unlocked=%b id=%b sdrd=%b oe=%b",
               n_step, unlocked, unlock_id, sdrd, sdrd_oe, e.u, e.id, e.s, e.oe);
    end else begin
      $display("step %0d rst=%b v=%b a=%h -> unlocked=%b id=%b sdrd=%b oe=%b ok",
               n_step, e.r, e.v, e.a, unlocked, unlock_id, sdrd, sdrd_oe);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst       = tbl[i].r;
      acc_valid = tbl[i].v;
      acc_addr  = tbl[i].a;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      check();
      n_step++;
    end
    tbl.delete();
  endtask

  initial begin
    keys = {16'h19A5, 16'hC3A5};   // key1 = 5,A,9,1 ; key0 = 5,A,3,C
    resp = {8'h3C, 8'hA5};

    // reset state
    add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);

    // back-to-back key0 -> stream A5
    unlock4(4'h5, 4'hA, 4'h3, 4'hC, 1'b0, 1'b0, 1'b1);
    stream_rest(8'hA5, 1'b0);

    // 5,5,A,3,C: restart on entry 0
    h(1'b1, 4'h5, 1'b0);
    unlock4(4'h5, 4'hA, 4'h3, 4'hC, 1'b0, 1'b0, 1'b1);
    stream_rest(8'hA5, 1'b0);

    // 9 idle cycles: one short of the timeout, progress kept
    h(1'b1, 4'h5, 1'b0);
    h(1'b1, 4'hA, 1'b0);
    idle(9, 1'b0);
    h(1'b1, 4'h3, 1'b0);
    add(1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1);
    stream_rest(8'hA5, 1'b0);

    // 10 idle cycles: progress discarded, then a fresh key unlocks
    h(1'b1, 4'h5, 1'b0);
    h(1'b1, 4'hA, 1'b0);
    idle(10, 1'b0);
    h(1'b1, 4'h3, 1'b0);
    h(1'b1, 4'hC, 1'b0);
    unlock4(4'h5, 4'hA, 4'h3, 4'hC, 1'b0, 1'b0, 1'b1);
    stream_rest(8'hA5, 1'b0);

    // key1 with 3 idle cycles between accesses -> stream 3C, id 1
    h(1'b1, 4'h5, 1'b0);
    idle(3, 1'b0);
    h(1'b1, 4'hA, 1'b0);
    idle(3, 1'b0);
    h(1'b1, 4'h9, 1'b0);
    idle(3, 1'b0);
    add(1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b1);
    stream_rest(8'h3C, 1'b1);

    // reset in HUNT with partial progress: clears id and idx
    h(1'b1, 4'h5, 1'b1);
    h(1'b1, 4'hA, 1'b1);
    add(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    h(1'b1, 4'hC, 1'b0);

    run_table();

    // Multi-cycle corner: reset mid-stream after 3 streamed bits
    unlock4(4'h5, 4'hA, 4'h9, 4'h1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    unlock4(4'h5, 4'hA, 4'h3, 4'hC, 1'b0, 1'b0, 1'b1);
    stream_rest(8'hA5, 1'b0);
    // leave unlock_id at 1 before the priority test
    unlock4(4'h5, 4'hA, 4'h9, 4'h1, 1'b0, 1'b1, 1'b0);
    stream_rest(8'h3C, 1'b1);
    run_table();

    // Multi-cycle corner: both channels complete together, lowest wins
    @(negedge clk);
    keys[31:16] = 16'hC3A5;
    unlock4(4'h5, 4'hA, 4'h3, 4'hC, 1'b1, 1'b0, 1'b1);
    stream_rest(8'hA5, 1'b0);
    run_table();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: %0d entries left, need 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_unlock_detector.md
SEQ_UNLOCK_DETECTOR -- requirements
Module: seq_unlock_detector

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: width of the compared access-address field.
REQ-002 SHALL have parameter KEY_LEN, default 6, legal range 2..16: entries per unlock key sequence.
REQ-003 SHALL have parameter NUM_KEYS, default 2, legal range 1..8: number of independent key channels.
REQ-004 SHALL have parameter RESP_W, default 8, legal range 1..32: response bits streamed per unlock.
REQ-005 SHALL have parameter TIMEOUT, default 255, legal range 1..65535: idle cycles before partial-match progress is discarded.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port acc_valid, input, 1 bit: one qualified access (decoded select and read/write already combined upstream) in this cycle.
REQ-009 SHALL have port acc_addr, input, ADDR_W bits: compared address field of the access.
REQ-010 SHALL have port keys, input, NUM_KEYS*KEY_LEN*ADDR_W bits: key k entry i at bits [(k*KEY_LEN+i)*ADDR_W +: ADDR_W]; static while rst is low.
REQ-011 SHALL have port resp, input, NUM_KEYS*RESP_W bits: response word of key k at [k*RESP_W +: RESP_W].
REQ-012 SHALL have port unlocked, output, 1 bit: high while in STREAM.
REQ-013 SHALL have port unlock_id, output, clog2(NUM_KEYS) bits (min 1): channel that unlocked.
REQ-014 SHALL have port sdrd, output, 1 bit: current response data bit.
REQ-015 SHALL have port sdrd_oe, output, 1 bit: sdrd valid/drive enable.

Function
REQ-016 SHALL implement a two-state FSM: HUNT and STREAM.
REQ-017 In HUNT, each channel k SHALL hold an index idx[k] in 0..KEY_LEN-1; on acc_valid, if acc_addr equals key k entry idx[k], idx[k] increments, else idx[k] becomes 1 if acc_addr equals entry 0, otherwise 0.
REQ-018 When a match occurs at idx[k]=KEY_LEN-1, the FSM SHALL enter STREAM on the next edge, latch unlock_id=k, load a shift register with resp word k, set bit counter to 0, and clear all idx.
REQ-019 If several channels complete in the same cycle, the lowest k SHALL win; others are cleared.
REQ-020 In HUNT, acc_valid low for TIMEOUT consecutive cycles SHALL clear all idx; the idle counter resets on any acc_valid and saturates.
REQ-021 In STREAM, unlocked and sdrd_oe SHALL be 1 and sdrd SHALL equal the current shift-register LSB (response bit 0 first), registered, with no combinational path from inputs.
REQ-022 In STREAM, each acc_valid SHALL advance one bit (shift right, counter+1); after the RESP_W-th acc_valid the FSM returns to HUNT on that edge with sdrd_oe=0.
REQ-023 In STREAM, acc_addr content SHALL be ignored (no key matching) and the idle timeout SHALL NOT apply.
REQ-024 In HUNT, unlocked=0, sdrd_oe=0, sdrd=0; unlock_id holds its last value.
REQ-025 Latency: unlocked rises exactly one cycle after the final matching access cycle.

Reset
REQ-026 rst high at a clock edge SHALL force HUNT, all idx=0, idle counter=0, shift register=0, bit counter=0, unlocked=0, unlock_id=0, sdrd=0, sdrd_oe=0, overriding acc_valid in the same cycle, including mid-STREAM.

Verification (KEY_LEN=4, ADDR_W=4, NUM_KEYS=2, RESP_W=8, TIMEOUT=10; key0=5,A,3,C; key1=5,A,9,1; resp0=0xA5, resp1=0x3C)
REQ-027 Accesses 5,A,3,C back-to-back -> unlocked=1, unlock_id=0 next cycle; 8 further accesses give sdrd 1,0,1,0,0,1,0,1, then unlocked=0.
REQ-028 Accesses 5,A,9,1 with 3 idle cycles between each -> unlock_id=1, stream 0,0,1,1,1,1,0,0.
REQ-029 Accesses 5,5,A,3,C -> unlocks channel 0 (restart-on-first-entry rule).
REQ-030 Accesses 5,A then 10 idle cycles then 3,C -> no unlock; following 5,A,3,C unlocks.
REQ-031 rst pulse after 3 streamed bits -> all outputs 0 next cycle; next 5,A,3,C restreams 0xA5 from bit 0.
REQ-032 Key1 set equal to key0, accesses 5,A,3,C -> unlock_id=0 (priority).
